// File: rtl/soi_tracer.sv
// soi_tracer: logs every change of a signal of interest as {value, timestamp} into a FWFT FIFO
// drained by a valid/ready host port. Optional `SOI_TRACER_TIMESTAMP_EN builds the timestamp path.
module soi_tracer #(
  parameter int W     = 1,
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [W-1:0]               soi,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [W-1:0]               rd_value,
  output logic [TS_W-1:0]            rd_time,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]                overflow_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  typedef enum logic {BASELINE, TRACK} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   prev_q;
  logic           push_req;
  logic           pop;
  logic           full;
  logic           wr_en;
  logic           drop;

  logic [W-1:0]   mem_val [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level_q;
  logic [15:0]    ovf_q;

  // ---------------------------------------------------------------------------
  // Change detector
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    push_req = 1'b0;
    if (!enable) begin
      state_d = BASELINE;
    end else begin
      case (state_q)
        BASELINE: begin
          push_req = 1'b1;
          state_d  = TRACK;
        end
        TRACK:    push_req = (soi != prev_q);
        default:  state_d  = BASELINE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its peers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BASELINE;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      // A push happens exactly when an enabled sample must become the new reference.
      if (push_req) prev_q <= soi;
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control: a pop in the same cycle frees the slot a full-FIFO push needs
  // ---------------------------------------------------------------------------
  assign rd_valid = (level_q != '0);
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  assign wr_en    = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ovf_q   <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end
  end

  // NOTE: storage is not reset; the pointers and occupancy define which entries
  // are meaningful, and reads of empty slots are masked to zero below.
  always_ff @(posedge clk) begin
    if (wr_en) mem_val[wr_ptr] <= soi;
  end

  assign rd_value     = rd_valid ? mem_val[rd_ptr] : '0;
  assign level        = level_q;
  assign overflow_cnt = ovf_q;

  // ---------------------------------------------------------------------------
  // Timestamp path
  // ---------------------------------------------------------------------------
`ifdef SOI_TRACER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] mem_ts [DEPTH];

  // Free-running and wrapping; the entry carries the value held before the push edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_ts[wr_ptr] <= ts_q;
  end

  assign rd_time = rd_valid ? mem_ts[rd_ptr] : '0;
`else
  assign rd_time = '0;
`endif

endmodule

// File: tb/tb_soi_tracer.sv
// Self-checking bench for soi_tracer: directed scenarios plus randomized traffic checked
// against a queue-based reference model; a second small instance covers timestamp wrap.
module tb_soi_tracer;

  localparam int W     = 1;
  localparam int DEPTH = 8;
  localparam int TS_W  = 16;
`ifdef SOI_TRACER_TIMESTAMP_EN
  localparam bit TS_ON = 1'b1;
`else
  localparam bit TS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [W-1:0]      soi = '0;
  logic              rd_ready = 1'b0;
  logic              rd_valid;
  logic [W-1:0]      rd_value;
  logic [TS_W-1:0]   rd_time;
  logic [3:0]        level;
  logic [15:0]       overflow_cnt;

  // Small instance: DEPTH 4, 4-bit timestamp for the wrap scenario.
  logic              en2 = 1'b0;
  logic              soi2 = 1'b0;
  logic              rdy2 = 1'b0;
  logic              rd_valid2;
  logic              rd_value2;
  logic [3:0]        rd_time2;
  logic [2:0]        level2;
  logic [15:0]       ovf2;

  always #5 clk = ~clk;

  soi_tracer #(.W(W), .DEPTH(DEPTH), .TS_W(TS_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .soi(soi), .rd_ready(rd_ready),
    .rd_valid(rd_valid), .rd_value(rd_value), .rd_time(rd_time),
    .level(level), .overflow_cnt(overflow_cnt)
  );

  soi_tracer #(.W(1), .DEPTH(4), .TS_W(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(en2), .soi(soi2), .rd_ready(rdy2),
    .rd_valid(rd_valid2), .rd_value(rd_value2), .rd_time(rd_time2),
    .level(level2), .overflow_cnt(ovf2)
  );

  int n_checks = 0;
  int n_pass   = 0;
  string phase = "init";

  // Reference model: the log is a plain queue of {value, time} entries.
  typedef struct {
    logic v;
    int   t;
  } ent_t;

  ent_t mq[$];
  int   m_ts;
  bit   m_need_base;
  logic m_prev;
  int   m_ovf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s.%s: observed %0h expected %0h", phase, tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ts        = 0;
    m_need_base = 1'b1;
    m_prev      = 1'b0;
    m_ovf       = 0;
  endtask

  // Apply one clock edge worth of the logging rules to the model using current inputs.
  task automatic model_step();
    bit do_pop;
    bit do_push;
    do_pop  = (mq.size() > 0) && rd_ready;
    do_push = enable && (m_need_base || soi != m_prev);
    if (do_pop) void'(mq.pop_front());
    if (do_push) begin
      if (mq.size() < DEPTH) mq.push_back('{soi, m_ts});
      else if (m_ovf < 65535) m_ovf++;
      m_prev = soi;
    end
    m_need_base = !enable;
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic check_main();
    chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
    chk("rd_value", 32'(rd_value), (mq.size() > 0) ? 32'(mq[0].v) : 32'd0);
    chk("rd_time",  32'(rd_time),  (mq.size() > 0 && TS_ON) ? 32'(mq[0].t) : 32'd0);
    chk("level",    32'(level),    32'(mq.size()));
    chk("overflow", 32'(overflow_cnt), 32'(m_ovf));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_main();
  endtask

  // Asserts reset between edges, checks the immediate clear, releases on the next negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_main();
    chk("wrap_valid", 32'(rd_valid2), 32'd0);
    chk("wrap_level", 32'(level2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_t;

    // Reset state
    phase = "reset";
    do_reset();

    // 1. Baseline capture
    phase = "baseline";
    enable = 1'b1;
    soi = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    chk("level_1", 32'(level), 32'd1);
    chk("value_1", 32'(rd_value), 32'd1);
    chk("time_0",  32'(rd_time), 32'd0);

    // 2. Toggle trace and overflow
    phase = "toggle";
    enable = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      soi = (i % 2 == 0);
      cycle();
    end
    chk("level_8", 32'(level), 32'd8);
    chk("head_time0", 32'(rd_time), 32'd0);
    for (int i = 8; i < 11; i++) begin
      soi = (i % 2 == 0);
      cycle();
    end
    chk("ovf_3", 32'(overflow_cnt), 32'd3);
    chk("level_still_8", 32'(level), 32'd8);

    // 3. Push and pop at full: no drop, head advances to second entry
    phase = "full_pop";
    soi = 1'b0;
    rd_ready = 1'b1;
    cycle();
    rd_ready = 1'b0;
    chk("level_8", 32'(level), 32'd8);
    chk("ovf_3", 32'(overflow_cnt), 32'd3);
    chk("head_value", 32'(rd_value), 32'd0);
    chk("head_time", 32'(rd_time), TS_ON ? 32'd1 : 32'd0);
    cycle();

    // 5. Disable and re-enable
    phase = "disable";
    enable = 1'b0;
    rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    rd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      soi = (i >= 2);
      cycle();
    end
    chk("no_entries", 32'(level), 32'd0);
    enable = 1'b1;
    soi = 1'b1;
    exp_t = TS_ON ? m_ts : 0;
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    chk("one_baseline", 32'(level), 32'd1);
    chk("base_value", 32'(rd_value), 32'd1);
    chk("base_time", 32'(rd_time), 32'(exp_t));

    // 4. Timestamp wrap on the 4-bit instance
    phase = "wrap";
    enable = 1'b0;
    do_reset();
    for (int e = 0; e < 18; e++) begin
      en2  = 1'b1;
      soi2 = (e == 15 || e == 16);
      rdy2 = (e < 15);
      cycle();
    end
    chk("level", 32'(level2), 32'd2);
    chk("first_value", 32'(rd_value2), 32'd1);
    chk("first_time", 32'(rd_time2), TS_ON ? 32'd15 : 32'd0);
    en2  = 1'b0;
    rdy2 = 1'b1;
    cycle();
    rdy2 = 1'b0;
    chk("second_value", 32'(rd_value2), 32'd0);
    chk("second_time", 32'(rd_time2), TS_ON ? 32'd1 : 32'd0);
    chk("level_after_pop", 32'(level2), 32'd1);

    // Randomized traffic: light draining first (overflows), then heavier draining
    phase = "random";
    for (int i = 0; i < 400; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      soi      = W'($urandom);
      rd_ready = ($urandom_range(0, 3) == 0);
      cycle();
    end
    for (int i = 0; i < 200; i++) begin
      enable   = ($urandom_range(0, 4) != 0);
      soi      = W'($urandom);
      rd_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    rd_ready = 1'b0;

    // 6. Reset mid-operation with 5 entries queued
    phase = "mid_reset";
    enable = 1'b0;
    do_reset();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      soi = (i % 2 == 0);
      cycle();
    end
    chk("queued_5", 32'(level), 32'd5);
    do_reset();
    chk("valid_0", 32'(rd_valid), 32'd0);
    chk("value_0", 32'(rd_value), 32'd0);
    chk("time_0", 32'(rd_time), 32'd0);
    chk("level_0", 32'(level), 32'd0);
    chk("ovf_0", 32'(overflow_cnt), 32'd0);
    soi = 1'b1;
    cycle();
    chk("first_time", 32'(rd_time), 32'd0);
    chk("first_value", 32'(rd_value), 32'd1);
    enable = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
